serial_sub_ctrl: RTL



---
 rtl/serial_sub_ctrl_pkg.sv | 17 +
 rtl/serial_sub_ctrl_cell.sv | 22 ++
 rtl/serial_sub_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller and anything that decodes its state.
package serial_sub_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// 1-bit full subtractor: two half-subtraction stages with the stage borrows ORed.
module full_sub_cell (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    always_comb begin
        d1   = ai ^ bi;
        b1   = ~ai & bi;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full_sub_cell.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, a_sh_nxt;
    logic [WIDTH-1:0] b_sh, b_sh_nxt;
    logic [WIDTH-1:0] d_sh, d_sh_nxt;
    logic [WIDTH-1:0] diff_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             bor, bor_nxt;
    logic             borrow_out_nxt;
    logic             in_ready_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] d_ins;

    full_sub_cell u_cell (
        .ai   (a_sh[0]),
        .bi   (b_sh[0]),
        .bin  (bor),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // Written as shift-and-OR so WIDTH=1 needs no empty part-select.
    assign d_ins = (d_sh >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_sh       <= a_sh_nxt;
            b_sh       <= b_sh_nxt;
            d_sh       <= d_sh_nxt;
            bor        <= bor_nxt;
            cnt        <= cnt_nxt;
            diff       <= diff_nxt;
            borrow_out <= borrow_out_nxt;
            in_ready   <= in_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        a_sh_nxt       = a_sh;
        b_sh_nxt       = b_sh;
        d_sh_nxt       = d_sh;
        bor_nxt        = bor;
        cnt_nxt        = cnt;
        diff_nxt       = diff;
        borrow_out_nxt = borrow_out;

        unique case (state)
            IDLE: begin
                if (start) begin
                    a_sh_nxt  = a;
                    b_sh_nxt  = b;
                    bor_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                d_sh_nxt = d_ins;
                a_sh_nxt = a_sh >> 1;
                b_sh_nxt = b_sh >> 1;
                bor_nxt  = cell_bo;
                cnt_nxt  = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    // Results only move here, so the previous answer stays readable while running.
                    cnt_nxt        = '0;
                    diff_nxt       = d_ins;
                    borrow_out_nxt = cell_bo;
                    state_nxt      = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt == RUN);
        done_nxt     = (state_nxt == DONE);
    end

endmodule
